// File: rtl/gaa_pkg.sv
// Shared definitions for the population loader.
// - SDRAM word address width
// - HPS slave register offsets, command bits and status bit positions
// - FIFO word type (lane enables travel with the data)
// - master FSM state type
package gaa_pkg;

  localparam int SDRAM_AW = 25;

  // HPS slave register offsets
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  // Command register bits
  localparam int CMD_RESTART = 0;
  localparam int CMD_FLUSH   = 1;

  // Status register bits
  localparam int ST_BUSY       = 0;
  localparam int ST_FIFO_EMPTY = 1;
  localparam int ST_OVERFLOW   = 2;
  localparam int ST_WRAPPED    = 3;

  // One buffered SDRAM write: active-low lane enables plus the 16-bit word
  typedef struct packed {
    logic [1:0]  be_n;
    logic [15:0] data;
  } gaa_word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } master_state_e;

endpackage

// File: rtl/gaa_word_fifo.sv
// Synchronous FIFO of gaa_word_t words with show-ahead output.
// Ports:
//   clk, reset   clock and synchronous active-high reset (empties the FIFO)
//   push, din    write din when not full
//   pop          advance the read pointer when not empty
//   dout         current head word (valid while empty=0)
//   full, empty  occupancy flags
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module gaa_word_fifo
  import gaa_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  gaa_word_t din,
  output gaa_word_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  gaa_word_t      mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Show-ahead: the head entry is visible without a read request
  assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/gaa_population_loader.sv
// Population loader: receives genome bytes from the HPS on an 8-bit Avalon-MM
// slave, packs byte pairs into 16-bit words, buffers them and writes them to a
// wrapping SDRAM window through an Avalon-MM write master.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   hps_address/chipselect/write/
//   hps_writedata/read/readdata/
//   hps_waitrequest                   HPS register slave (0 data, 1 cmd, 2 status, 3 count)
//   sdram_address/byteenable_n/
//   sdram_chipselect/write_n/
//   sdram_writedata/waitrequest       SDRAM write master (word addressed)
module gaa_population_loader
  import gaa_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] BASE_ADDR    = '0,
  parameter int                  REGION_WORDS = 1024,
  parameter int                  FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          hps_address,
  input  logic                hps_chipselect,
  input  logic                hps_write,
  input  logic [7:0]          hps_writedata,
  input  logic                hps_read,
  output logic [7:0]          hps_readdata,
  output logic                hps_waitrequest,
  output logic [SDRAM_AW-1:0] sdram_address,
  output logic [1:0]          sdram_byteenable_n,
  output logic                sdram_chipselect,
  output logic                sdram_write_n,
  output logic [15:0]         sdram_writedata,
  input  logic                sdram_waitrequest
);

  localparam logic [SDRAM_AW-1:0] LAST_ADDR = BASE_ADDR + SDRAM_AW'(REGION_WORDS - 1);

  // Slave decode
  logic      wr_data;
  logic      wr_cmd;
  logic      flush_req;
  logic      restart_req;
  logic      push_needed;
  logic      accept_wr;

  // Byte packer
  logic      pending_reg;
  logic [7:0] low_byte_reg;

  // FIFO interface
  logic      fifo_push;
  logic      fifo_pop;
  gaa_word_t fifo_din;
  gaa_word_t fifo_dout;
  logic      fifo_full;
  logic      fifo_empty;

  // Master and status
  master_state_e state_reg;
  logic       sdram_ack;
  logic       restart_ok;
  logic [7:0] word_count_reg;
  logic       wrapped_reg;
  logic       overflow_reg;
  logic       busy;
  logic [7:0] status_byte;
  logic [7:0] read_mux;

  // ------------------------------------------------------------------
  // Slave decode and backpressure
  // ------------------------------------------------------------------
  assign wr_data     = hps_chipselect && hps_write && (hps_address == REG_DATA);
  assign wr_cmd      = hps_chipselect && hps_write && (hps_address == REG_CMD);
  assign flush_req   = wr_cmd && hps_writedata[CMD_FLUSH];
  assign restart_req = wr_cmd && hps_writedata[CMD_RESTART];

  // Only a write that would complete a word can need FIFO space; a lone
  // first byte is simply latched and never stalls.
  assign push_needed = (wr_data || flush_req) && pending_reg;

  // Full is checked without crediting a same-cycle pop: one extra stall
  // cycle is cheaper than a combinational path from sdram_waitrequest.
  assign hps_waitrequest = reset || (hps_chipselect && hps_write && push_needed && fifo_full);
  assign accept_wr       = hps_chipselect && hps_write && !hps_waitrequest;

  assign fifo_push = accept_wr && push_needed;

  always_comb begin
    fifo_din = '0;
    if (wr_data) begin
      fifo_din.be_n = 2'b00;
      fifo_din.data = {hps_writedata, low_byte_reg};
    end else begin
      // Flush of an odd byte: only the low lane is written
      fifo_din.be_n = 2'b10;
      fifo_din.data = {8'h00, low_byte_reg};
    end
  end

  // ------------------------------------------------------------------
  // Byte packer
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg  <= 1'b0;
      low_byte_reg <= '0;
    end else if (accept_wr) begin
      if (wr_data) begin
        if (!pending_reg) begin
          low_byte_reg <= hps_writedata;
          pending_reg  <= 1'b1;
        end else begin
          pending_reg  <= 1'b0;
        end
      end else if (flush_req && pending_reg) begin
        pending_reg <= 1'b0;
      end
    end
  end

  gaa_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ------------------------------------------------------------------
  // Write master
  // ------------------------------------------------------------------
  assign sdram_ack = (state_reg == WRITE) && !sdram_waitrequest;

  // Load the next word either from idle or directly behind an accepted
  // word, which gives one word per clock while SDRAM keeps up.
  assign fifo_pop = !fifo_empty && ((state_reg == IDLE) || sdram_ack);

  // Restart must not move the pointer under a word still in flight
  assign restart_ok = accept_wr && restart_req && fifo_empty && (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      sdram_chipselect   <= 1'b0;
      sdram_write_n      <= 1'b1;
      sdram_byteenable_n <= 2'b11;
      sdram_writedata    <= '0;
    end else if (fifo_pop) begin
      state_reg          <= WRITE;
      sdram_chipselect   <= 1'b1;
      sdram_write_n      <= 1'b0;
      sdram_byteenable_n <= fifo_dout.be_n;
      sdram_writedata    <= fifo_dout.data;
    end else if (sdram_ack) begin
      state_reg          <= IDLE;
      sdram_chipselect   <= 1'b0;
      sdram_write_n      <= 1'b1;
      sdram_byteenable_n <= 2'b11;
    end
  end

  // Address pointer, accepted-word counter and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      sdram_address  <= BASE_ADDR;
      word_count_reg <= '0;
      wrapped_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (sdram_ack) begin
        word_count_reg <= word_count_reg + 8'd1;
        if (sdram_address == LAST_ADDR) begin
          sdram_address <= BASE_ADDR;
          wrapped_reg   <= 1'b1;
        end else begin
          sdram_address <= sdram_address + SDRAM_AW'(1);
        end
      end else if (restart_ok) begin
        sdram_address  <= BASE_ADDR;
        word_count_reg <= '0;
        wrapped_reg    <= 1'b0;
      end
      // Should never fire: the slave stalls before a push into a full FIFO
      if (fifo_push && fifo_full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Status and read-back
  // ------------------------------------------------------------------
  assign busy = !fifo_empty || (state_reg == WRITE) || pending_reg;

  always_comb begin
    status_byte                = '0;
    status_byte[ST_BUSY]       = busy;
    status_byte[ST_FIFO_EMPTY] = fifo_empty;
    status_byte[ST_OVERFLOW]   = overflow_reg;
    status_byte[ST_WRAPPED]    = wrapped_reg;
  end

  always_comb begin
    read_mux = '0;
    case (hps_address)
      REG_STATUS: read_mux = status_byte;
      REG_COUNT:  read_mux = word_count_reg;
      default:    read_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hps_readdata <= '0;
    end else if (hps_chipselect && hps_read) begin
      hps_readdata <= read_mux;
    end
  end

endmodule
